// File: rtl/route_sched_ctrl.sv
// Slot-table scheduler for the TOP MUX/DEMUX select lines and outFIFO read gating.
// Steps slots 0..last_slot with a one-cycle settle guard before every dwell.
module route_sched_ctrl #(
   parameter int unsigned NSLOT = 8,
   parameter int unsigned SW    = 3,
   parameter int unsigned DW    = 4
) (
   input  logic            inClock,
   input  logic            inReset,
   input  logic            cfg_we,
   input  logic [SW-1:0]   cfg_addr,
   input  logic [17+DW:0]  cfg_data,
   output logic            cfg_err,
   input  logic            start,
   input  logic            stop,
   input  logic            loop_en,
   input  logic [SW-1:0]   last_slot,
   input  logic            fifo_empty,
   output logic [2:0]      sel1,
   output logic [2:0]      sel2,
   output logic [1:0]      sel6,
   output logic [1:0]      sel9,
   output logic [2:0]      sel15,
   output logic            sel3,
   output logic            sel11,
   output logic            sel12,
   output logic            sel17,
   output logic            rd_en,
   output logic            busy,
   output logic            done,
   output logic [SW-1:0]   slot
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      DWELL
   } state_t;

   typedef struct packed {
      logic          rd;
      logic          sel17;
      logic          sel12;
      logic          sel11;
      logic          sel3;
      logic [2:0]    sel15;
      logic [1:0]    sel9;
      logic [1:0]    sel6;
      logic [2:0]    sel2;
      logic [2:0]    sel1;
      logic [DW-1:0] dwell;
   } slotWord_t;

   slotWord_t     slotTable [NSLOT];
   slotWord_t     loadWord;

   state_t        state;
   state_t        stateNext;
   logic [DW-1:0] dwellCnt;
   logic [DW-1:0] dwellCntNext;
   logic [SW-1:0] slotNext;
   logic [SW-1:0] lastSlot;
   logic [SW-1:0] lastSlotNext;
   logic          loopEn;
   logic          loopEnNext;
   logic          curRd;
   logic          loadSlot;
   logic          rdEnNext;
   logic          busyNext;
   logic          doneNext;
   logic          cfgErrNext;

   // Table is only writable while idle so a running sequence never sees a torn slot.
   always_ff @(posedge inClock or negedge inReset) begin
      if (!inReset) begin
         for (int i = 0; i < int'(NSLOT); i++) begin
            slotTable[i] <= '0;
         end
      end else if (cfg_we && !busy) begin
         slotTable[cfg_addr] <= slotWord_t'(cfg_data);
      end
   end

   // Next-state and next-output decode; every registered output is computed here.
   always_comb begin
      stateNext    = state;
      slotNext     = slot;
      dwellCntNext = dwellCnt;
      loopEnNext   = loopEn;
      lastSlotNext = lastSlot;
      loadSlot     = 1'b0;
      doneNext     = 1'b0;
      cfgErrNext   = cfg_we && busy;

      unique case (state)
         IDLE: begin
            if (start) begin
               loopEnNext   = loop_en;
               lastSlotNext = last_slot;
               slotNext     = '0;
               loadSlot     = 1'b1;
               stateNext    = SETTLE;
            end
         end
         SETTLE: begin
            stateNext = stop ? IDLE : DWELL;
         end
         DWELL: begin
            if (stop) begin
               stateNext = IDLE;
            end else if (dwellCnt == '0) begin
               if (slot < lastSlot) begin
                  slotNext  = slot + SW'(1);
                  loadSlot  = 1'b1;
                  stateNext = SETTLE;
               end else if (loopEn) begin
                  slotNext  = '0;
                  loadSlot  = 1'b1;
                  stateNext = SETTLE;
               end else begin
                  doneNext  = 1'b1;
                  stateNext = IDLE;
               end
            end else begin
               dwellCntNext = dwellCnt - DW'(1);
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase

      loadWord = slotTable[slotNext];
      if (loadSlot) begin
         dwellCntNext = loadWord.dwell;
      end

      busyNext = (stateNext != IDLE);
      rdEnNext = (stateNext == DWELL) && curRd && !fifo_empty;
   end

   // State and output registers; selects change only when a new slot is loaded.
   always_ff @(posedge inClock or negedge inReset) begin
      if (!inReset) begin
         state    <= IDLE;
         slot     <= '0;
         dwellCnt <= '0;
         loopEn   <= 1'b0;
         lastSlot <= '0;
         curRd    <= 1'b0;
         sel1     <= '0;
         sel2     <= '0;
         sel6     <= '0;
         sel9     <= '0;
         sel15    <= '0;
         sel3     <= 1'b0;
         sel11    <= 1'b0;
         sel12    <= 1'b0;
         sel17    <= 1'b0;
         rd_en    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         state    <= stateNext;
         slot     <= slotNext;
         dwellCnt <= dwellCntNext;
         loopEn   <= loopEnNext;
         lastSlot <= lastSlotNext;
         rd_en    <= rdEnNext;
         busy     <= busyNext;
         done     <= doneNext;
         cfg_err  <= cfgErrNext;
         if (loadSlot) begin
            curRd <= loadWord.rd;
            sel1  <= loadWord.sel1;
            sel2  <= loadWord.sel2;
            sel6  <= loadWord.sel6;
            sel9  <= loadWord.sel9;
            sel15 <= loadWord.sel15;
            sel3  <= loadWord.sel3;
            sel11 <= loadWord.sel11;
            sel12 <= loadWord.sel12;
            sel17 <= loadWord.sel17;
         end
      end
   end

endmodule

// File: tb/tb_route_sched_ctrl.sv
// Bench for route_sched_ctrl: slot-position reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_route_sched_ctrl;

   logic        clk;
   logic        rst_n;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [21:0] cfg_data;
   logic        cfg_err;
   logic        start;
   logic        stop;
   logic        loop_en;
   logic [2:0]  last_slot;
   logic        fifo_empty;
   logic [2:0]  sel1;
   logic [2:0]  sel2;
   logic [1:0]  sel6;
   logic [1:0]  sel9;
   logic [2:0]  sel15;
   logic        sel3;
   logic        sel11;
   logic        sel12;
   logic        sel17;
   logic        rd_en;
   logic        busy;
   logic        done;
   logic [2:0]  slot;

   route_sched_ctrl #(.NSLOT(8), .SW(3), .DW(4)) dut (
      .inClock   (clk),
      .inReset   (rst_n),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_err   (cfg_err),
      .start     (start),
      .stop      (stop),
      .loop_en   (loop_en),
      .last_slot (last_slot),
      .fifo_empty(fifo_empty),
      .sel1      (sel1),
      .sel2      (sel2),
      .sel6      (sel6),
      .sel9      (sel9),
      .sel15     (sel15),
      .sel3      (sel3),
      .sel11     (sel11),
      .sel12     (sel12),
      .sel17     (sel17),
      .rd_en     (rd_en),
      .busy      (busy),
      .done      (done),
      .slot      (slot)
   );

   int nChecks = 0;
   int nFails  = 0;
   int cyc     = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nFails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Word layout MSB..LSB: rd sel17 sel12 sel11 sel3 sel15 sel9 sel6 sel2 sel1 dwell
   function automatic logic [21:0] mkWord(input int rd, input int s17, input int s12,
                                          input int s11, input int s3, input int s15,
                                          input int s9, input int s6, input int s2,
                                          input int s1, input int dw);
      return {1'(rd), 1'(s17), 1'(s12), 1'(s11), 1'(s3), 3'(s15), 2'(s9), 2'(s6),
              3'(s2), 3'(s1), 4'(dw)};
   endfunction

   // Reference model: tracks which slot is active and the position inside its
   // dwell+2 cycle period (0 = settle guard, 1..dwell+1 = dwell).
   logic [21:0] mTab [8];
   logic [21:0] mWord;
   logic [2:0]  mSlot;
   logic [2:0]  mLast;
   logic        mLoop;
   logic        mBusy;
   logic        mRd;
   logic        mDone;
   logic        mErr;
   int          mPos;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) mTab[i] = '0;
         mWord = '0; mSlot = '0; mLast = '0; mLoop = 1'b0;
         mBusy = 1'b0; mRd = 1'b0; mDone = 1'b0; mErr = 1'b0; mPos = 0;
      end else begin
         mErr  = cfg_we && mBusy;
         mDone = 1'b0;
         if (!mBusy) begin
            if (start) begin
               mLoop = loop_en; mLast = last_slot;
               mSlot = '0; mPos = 0; mWord = mTab[0]; mBusy = 1'b1;
            end
         end else if (stop) begin
            mBusy = 1'b0;
         end else if (mPos == int'(mWord[3:0]) + 1) begin
            if (mSlot < mLast) begin
               mSlot = mSlot + 3'd1; mPos = 0; mWord = mTab[mSlot];
            end else if (mLoop) begin
               mSlot = '0; mPos = 0; mWord = mTab[0];
            end else begin
               mBusy = 1'b0; mDone = 1'b1;
            end
         end else begin
            mPos++;
         end
         mRd = mBusy && (mPos > 0) && mWord[21] && !fifo_empty;
         if (cfg_we && !(mErr)) mTab[cfg_addr] = cfg_data;
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("sel1",   int'(sel1),   int'(mWord[6:4]));
      chk("sel2",   int'(sel2),   int'(mWord[9:7]));
      chk("sel6",   int'(sel6),   int'(mWord[11:10]));
      chk("sel9",   int'(sel9),   int'(mWord[13:12]));
      chk("sel15",  int'(sel15),  int'(mWord[16:14]));
      chk("sel3",   int'(sel3),   int'(mWord[17]));
      chk("sel11",  int'(sel11),  int'(mWord[18]));
      chk("sel12",  int'(sel12),  int'(mWord[19]));
      chk("sel17",  int'(sel17),  int'(mWord[20]));
      chk("rd_en",  int'(rd_en),  int'(mRd));
      chk("busy",   int'(busy),   int'(mBusy));
      chk("done",   int'(done),   int'(mDone));
      chk("slot",   int'(slot),   int'(mSlot));
      chk("cfgerr", int'(cfg_err), int'(mErr));
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wr(input int a, input logic [21:0] d);
      cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = d;
      step();
      cfg_we = 1'b0;
   endtask

   // Pulses start for one edge; returns at the first cycle after start (T+1).
   task automatic go(input int lp, input int last);
      loop_en = 1'(lp); last_slot = 3'(last); start = 1'b1;
      step();
      start = 1'b0;
   endtask

   int  rdCnt;
   int  doneAt;
   int  doneCnt;
   bit  pat [5];

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
      stop = 1'b0; loop_en = 1'b0; last_slot = '0; fifo_empty = 1'b0;
      repeat (3) step();
      #2 rst_n = 1'b1;
      step();
      chk("idle_busy", int'(busy), 0);
      chk("idle_sel1", int'(sel1), 0);

      // All-zero table: settle, one dwell cycle, done
      go(0, 0);
      chk("zero_settle_busy", int'(busy), 1);
      step();
      chk("zero_dwell_done", int'(done), 0);
      step();
      chk("zero_done", int'(done), 1);
      chk("zero_done_busy", int'(busy), 0);
      step();

      // Stop on the final dwell cycle suppresses done
      go(0, 0);
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_end_done", int'(done), 0);
      chk("stop_end_busy", int'(busy), 0);
      step();

      // Single slot, dwell 3
      wr(0, mkWord(1, 0, 0, 0, 0, 6, 0, 0, 0, 5, 3));
      fifo_empty = 1'b0;
      go(0, 0);
      chk("single_sel1", int'(sel1), 5);
      chk("single_sel15", int'(sel15), 6);
      chk("single_settle_rd", int'(rd_en), 0);
      rdCnt = 0;
      for (int k = 2; k <= 5; k++) begin
         step();
         rdCnt += int'(rd_en);
      end
      chk("single_rd_cycles", rdCnt, 4);
      step();
      chk("single_done", int'(done), 1);
      chk("single_busy", int'(busy), 0);
      step();

      // Three slots, dwells 0/1/2
      wr(0, mkWord(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      wr(1, mkWord(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1));
      wr(2, mkWord(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 2));
      go(0, 2);
      doneAt = 0;
      for (int k = 1; k <= 11; k++) begin
         if (k == 1) begin chk("seq_sel6_a", int'(sel6), 1); chk("seq_settle_rd_a", int'(rd_en), 0); end
         if (k == 3) begin chk("seq_sel6_b", int'(sel6), 2); chk("seq_settle_rd_b", int'(rd_en), 0); end
         if (k == 6) begin chk("seq_sel6_c", int'(sel6), 3); chk("seq_settle_rd_c", int'(rd_en), 0); end
         if (done && doneAt == 0) doneAt = k;
         if (k < 11) step();
      end
      chk("seq_done_at", doneAt, 10);
      step();

      // FIFO gating: rd_en reflects the empty flag sampled on the prior edge
      wr(0, mkWord(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
      pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      go(0, 0);
      rdCnt = 0;
      for (int i = 0; i < 5; i++) begin
         fifo_empty = pat[i];
         step();
         rdCnt += int'(rd_en);
      end
      chk("fifo_rd_count", rdCnt, 3);
      fifo_empty = 1'b0;
      repeat (2) step();

      // Loop over two slots, then abort in the second pass
      wr(0, mkWord(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
      wr(1, mkWord(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1));
      go(1, 1);
      for (int k = 1; k <= 11; k++) begin
         if (k == 1 || k == 7)  chk("loop_slot0", int'(slot), 0);
         if (k == 4 || k == 10) chk("loop_slot1", int'(slot), 1);
         if (k < 11) step();
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("loop_stop_busy", int'(busy), 0);
      chk("loop_stop_rd", int'(rd_en), 0);
      doneCnt = 0;
      for (int k = 0; k < 5; k++) begin
         doneCnt += int'(done);
         step();
      end
      chk("loop_stop_nodone", doneCnt, 0);

      // Config write while busy is dropped; idle write lands
      wr(0, mkWord(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3));
      go(0, 0);
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = mkWord(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 3);
      step();
      cfg_we = 1'b0;
      chk("busy_cfg_err", int'(cfg_err), 1);
      repeat (6) step();
      go(0, 0);
      chk("busy_write_dropped", int'(sel1), 3);
      repeat (6) step();
      wr(0, mkWord(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 3));
      go(0, 0);
      chk("idle_write_lands", int'(sel1), 6);
      repeat (3) step();

      // Reset mid-sequence aborts without done
      #2 rst_n = 1'b0;
      step();
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      #2 rst_n = 1'b1;
      step();

      // Randomized soak
      for (int n = 0; n < 3000; n++) begin
         start      = ($urandom_range(0, 11) == 0);
         stop       = ($urandom_range(0, 40) == 0);
         cfg_we     = ($urandom_range(0, 6) == 0);
         cfg_addr   = 3'($urandom);
         cfg_data   = 22'($urandom);
         loop_en    = ($urandom_range(0, 3) == 0);
         last_slot  = 3'($urandom);
         fifo_empty = 1'($urandom);
         step();
      end
      start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
      repeat (2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/route_sched_ctrl.md
Name: route_sched_ctrl

Overview:
- Programmable scheduler that sequences the select lines of the TOP MUX/DEMUX routing datapath and gates the outFIFO read enable.
- Holds a small table of routing "slots". Each slot is a full select configuration plus a dwell time.
- On start, steps through slots 0..last_slot, with optional looping, and inserts a one-cycle settle guard on every reconfiguration.
- Sits in the core beside TOP and replaces direct pad-driven select control.

Parameters:
- NSLOT, 8, number of table entries (power of 2, 2..16).
- SW, 3, slot index width = log2(NSLOT).
- DW, 4, dwell counter width.

Ports:
- inClock  in  1  core clock.
- inReset  in  1  asynchronous, active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  SW  table write index.
- cfg_data  in  18+DW  slot word. Bit fields, MSB to LSB: rd(1), sel17(1), sel12(1), sel11(1), sel3(1), sel15(3), sel9(2), sel6(2), sel2(3), sel1(3), dwell(DW).
- cfg_err  out  1  one-cycle pulse when cfg_we arrives while busy.
- start  in  1  start pulse.
- stop  in  1  abort request.
- loop_en  in  1  sampled at start; 1 means wrap after last slot.
- last_slot  in  SW  sampled at start; index of the final slot.
- fifo_empty  in  1  outFIFO empty flag.
- sel1, sel2  out  3 each  DEMUX selects.
- sel6, sel9  out  2 each  MUX selects.
- sel15  out  3  MUX select.
- sel3, sel11, sel12, sel17  out  1 each  selects.
- rd_en  out  1  outFIFO read enable.
- busy  out  1  sequence active.
- done  out  1  one-cycle completion pulse.
- slot  out  SW  current slot index.

Behaviour:
- Reset (inReset=0, asynchronous):
  - All outputs go to 0.
  - State goes to IDLE.
  - All table entries clear to 0.
  - Latched loop_en and last_slot clear to 0.
- Reset mid-sequence aborts immediately. No done pulse is generated.
- All outputs are registered.
- Table writes:
  - When cfg_we=1 and busy=0, the table entry at cfg_addr is written on the clock edge.
  - When cfg_we=1 and busy=1, the write is dropped and cfg_err pulses for 1 cycle.
- States: IDLE, SETTLE, DWELL.
- IDLE:
  - busy=0, rd_en=0. The sel outputs hold their last values.
  - start=1 latches loop_en and last_slot, sets slot=0, and moves to SETTLE.
  - In IDLE, start wins over a simultaneous stop.
- SETTLE (exactly 1 cycle):
  - The sel outputs show the current slot's fields.
  - rd_en=0, busy=1.
  - Dwell counter loads the slot's dwell value.
  - Next state is DWELL.
- DWELL (dwell+1 cycles; dwell=0 means 1 cycle):
  - The sel outputs are held.
  - rd_en = slot.rd AND NOT fifo_empty, evaluated combinationally from the registered state and registered into rd_en the same cycle. There is no read when the FIFO is empty.
  - The counter decrements each cycle. When it reaches 0, the slot ends.
- End of slot:
  - If slot < latched last_slot: slot+1, go to SETTLE.
  - Else if loop_en is latched: slot=0, go to SETTLE.
  - Else: go to IDLE with done=1 for 1 cycle and busy=0. slot holds last_slot.
- Slot period is dwell+2 cycles.
- Timing with start at cycle T and a single slot with dwell d:
  - SETTLE at T+1.
  - DWELL from T+2 to T+2+d.
  - done at T+3+d.
- stop while busy:
  - Forces IDLE on the next edge, with rd_en=0 and busy=0.
  - No done pulse. The sel outputs hold.
  - A stop that arrives in the same cycle as the end of the last slot suppresses done.
- start while busy is ignored.
- If last_slot ≥ NSLOT it is not possible by width. Any index is legal.
- Changes to loop_en or last_slot after start have no effect until the next start.

Test Plan:
- Reset then idle: inReset low for 3 cycles, then release. Required: all outputs 0, busy=0. A start with an all-zero table gives SETTLE at T+1, a 1-cycle DWELL at T+2, and done at T+3.
- Single slot timing: write slot0 = {rd=1, sel1=5, sel15=6, dwell=3}, fifo_empty=0, last_slot=0, start at T. Required: sel1=5 and sel15=6 at T+1; rd_en=1 from T+2 to T+5; done at T+6; busy low at T+6.
- Three-slot sequence: dwells 0/1/2, distinct sel6 values 1/2/3, last_slot=2. Required: sel6 changes at T+1, T+3, T+6; rd_en is 0 on every SETTLE cycle; done at T+10.
- FIFO gating: slot rd=1, dwell=4, fifo_empty toggling 0,1,0,1,0. Required: rd_en follows NOT fifo_empty in the DWELL cycles and is never 1 while empty.
- Loop and stop: loop_en=1, last_slot=1, dwells 1/1. Required: slot goes 0,1,0,1. A stop asserted during the second pass gives IDLE on the next edge, rd_en=0, and no done pulse.
- Config while busy: cfg_we to slot0 during a sequence. Required: cfg_err pulses once, slot0 contents are unchanged on the next run, and a write while idle succeeds.
